// File: rtl/rr_stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer: mode encodings
// and the packet-lock state used when RR_STREAM_MUX_LOCK_EN is defined.
package rr_stream_mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FORCE = 1'b1;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// Combinational rotating-priority arbiter: grants the first requester found
// after (i_advance=1) or starting at (i_advance=0) the supplied pointer.
module rr_arbiter #(
  parameter int N_CH = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  i_req,
  input  logic [SEL_W-1:0] i_ptr,
  input  logic             i_advance,
  output logic [N_CH-1:0]  o_grant,
  output logic [SEL_W-1:0] o_grantIdx
);

  logic             w_found;
  logic [SEL_W-1:0] w_idx;

  always_comb begin
    o_grant    = '0;
    o_grantIdx = '0;
    w_found    = 1'b0;
    w_idx      = '0;
    for (int off = 0; off < N_CH; off++) begin
      w_idx = SEL_W'((int'(i_ptr) + int'(i_advance) + off) % N_CH);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grantIdx     = w_idx;
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// Registered N-channel valid/ready stream mux with round-robin or forced select.
// Define RR_STREAM_MUX_LOCK_EN to keep round-robin grants locked for a whole packet.
module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH-1:0]        in_last,
  output logic [N_CH-1:0]        in_ready,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       force_sel,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [SEL_W-1:0]       out_sel,
  input  logic                   out_ready
);

  logic [SEL_W-1:0]  r_ptr;
  logic              r_outValid;
  logic [DATA_W-1:0] r_outData;
  logic              r_outLast;
  logic [SEL_W-1:0]  r_outSel;

  logic              w_loadEn;
  logic [N_CH-1:0]   w_rrGrant;
  logic [SEL_W-1:0]  w_rrIdx;
  logic [N_CH-1:0]   w_grant;
  logic [SEL_W-1:0]  w_grantIdx;
  logic              w_xfer;
  logic [DATA_W-1:0] w_selData;
  logic              w_selLast;

`ifdef RR_STREAM_MUX_LOCK_EN
  lock_state_e       r_lockState;
  logic [SEL_W-1:0]  r_lockCh;
`endif

  assign w_loadEn = !r_outValid || out_ready;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .i_req      (in_valid),
    .i_ptr      (r_ptr),
    .i_advance  (1'b1),
    .o_grant    (w_rrGrant),
    .o_grantIdx (w_rrIdx)
  );

  // Forced select only matches in-range indices, so out-of-range never grants.
  always_comb begin
    w_grant    = '0;
    w_grantIdx = '0;
    if (mode == MODE_FORCE) begin
      for (int i = 0; i < N_CH; i++) begin
        if (force_sel == SEL_W'(i)) begin
          w_grant[i] = in_valid[i];
          w_grantIdx = force_sel;
        end
      end
    end
`ifdef RR_STREAM_MUX_LOCK_EN
    else if (r_lockState == LOCK_HELD) begin
      for (int i = 0; i < N_CH; i++) begin
        if (r_lockCh == SEL_W'(i)) begin
          w_grant[i] = in_valid[i];
          w_grantIdx = r_lockCh;
        end
      end
    end
`endif
    else begin
      w_grant    = w_rrGrant;
      w_grantIdx = w_rrIdx;
    end
  end

  assign w_xfer   = |(w_grant & {N_CH{w_loadEn}});
  assign in_ready = rst ? '0 : (w_grant & {N_CH{w_loadEn}});

  always_comb begin
    w_selData = '0;
    w_selLast = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_grant[i]) begin
        w_selData = in_data[i*DATA_W +: DATA_W];
        w_selLast = in_last[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outLast  <= 1'b0;
      r_outSel   <= '0;
    end else if (w_loadEn) begin
      r_outValid <= w_xfer;
      if (w_xfer) begin
        r_outData <= w_selData;
        r_outLast <= w_selLast;
        r_outSel  <= w_grantIdx;
      end
    end
  end

  // Pointer moves only on accepted round-robin beats; under lock, only on the packet's last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= SEL_W'(N_CH - 1);
`ifdef RR_STREAM_MUX_LOCK_EN
      r_lockState <= LOCK_IDLE;
      r_lockCh    <= '0;
    end else if (mode == MODE_FORCE) begin
      r_lockState <= LOCK_IDLE;
    end else if (w_xfer) begin
      if (w_selLast) begin
        r_lockState <= LOCK_IDLE;
        r_ptr       <= w_grantIdx;
      end else begin
        r_lockState <= LOCK_HELD;
        r_lockCh    <= w_grantIdx;
      end
    end
`else
    end else if (mode == MODE_RR && w_xfer) begin
      r_ptr <= w_grantIdx;
    end
`endif
  end

  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_last  = r_outLast;
  assign out_sel   = r_outSel;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench for rr_stream_mux: directed vector tables, a randomized
// run against a behavioural model, and a 6-channel out-of-range select check.
module tb_rr_stream_mux;

  localparam int N_CH   = 4;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inData;
  logic [3:0]  inValid;
  logic [3:0]  inLast;
  logic [3:0]  inReady;
  logic        mode;
  logic [1:0]  forceSel;
  logic [7:0]  outData;
  logic        outValid;
  logic        outLast;
  logic [1:0]  outSel;
  logic        outReady;

  logic [47:0] d6Data;
  logic [5:0]  d6Valid;
  logic [5:0]  d6Last;
  logic [5:0]  d6Ready;
  logic        d6Mode;
  logic [2:0]  d6ForceSel;
  logic [7:0]  d6OutData;
  logic        d6OutValid;
  logic        d6OutLast;
  logic [2:0]  d6OutSel;
  logic        d6OutReady;

  int checks = 0;
  int errors = 0;

  // Behavioural model state, updated once per clock from the arbitration rules
  int          mPtr;
  bit          mValid;
  logic [7:0]  mData;
  bit          mLast;
  int          mSel;
  bit          mLocked;
  int          mLockCh;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        mode;
    logic [1:0]  fsel;
    logic        oready;
    logic [3:0]  expReady;
    logic        expValid;
    logic [1:0]  expSel;
    logic [7:0]  expData;
    logic        expLast;
  } vec_t;

  always #5 clk = ~clk;

  rr_stream_mux #(.N_CH(N_CH), .DATA_W(DATA_W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (inData),
    .in_valid  (inValid),
    .in_last   (inLast),
    .in_ready  (inReady),
    .mode      (mode),
    .force_sel (forceSel),
    .out_data  (outData),
    .out_valid (outValid),
    .out_last  (outLast),
    .out_sel   (outSel),
    .out_ready (outReady)
  );

  rr_stream_mux #(.N_CH(6), .DATA_W(DATA_W)) u_dut6 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (d6Data),
    .in_valid  (d6Valid),
    .in_last   (d6Last),
    .in_ready  (d6Ready),
    .mode      (d6Mode),
    .force_sel (d6ForceSel),
    .out_data  (d6OutData),
    .out_valid (d6OutValid),
    .out_last  (d6OutLast),
    .out_sel   (d6OutSel),
    .out_ready (d6OutReady)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                               input logic m, input logic [1:0] fs, input logic ordy);
    inValid  = v;
    inLast   = l;
    inData   = d;
    mode     = m;
    forceSel = fs;
    outReady = ordy;
  endtask

  task automatic runVector(input vec_t v, input string tag, input int idx);
    applyStimulus(v.valid, v.last, v.data, v.mode, v.fsel, v.oready);
    #2;
    checkOutput($sformatf("%s[%0d].in_ready", tag, idx), 32'(inReady), 32'(v.expReady));
    @(posedge clk);
    #1;
    checkOutput($sformatf("%s[%0d].out_valid", tag, idx), 32'(outValid), 32'(v.expValid));
    if (v.expValid) begin
      checkOutput($sformatf("%s[%0d].out_sel", tag, idx), 32'(outSel), 32'(v.expSel));
      checkOutput($sformatf("%s[%0d].out_data", tag, idx), 32'(outData), 32'(v.expData));
      checkOutput($sformatf("%s[%0d].out_last", tag, idx), 32'(outLast), 32'(v.expLast));
    end
  endtask

  task automatic resetDut();
    applyStimulus(4'h0, 4'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    rst = 1'b1;
    #2;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic int modelGrant(input logic [3:0] v, input logic m, input logic [1:0] fs);
    if (m) return v[fs] ? int'(fs) : -1;
    if (mLocked) return v[mLockCh] ? mLockCh : -1;
    for (int k = 1; k <= N_CH; k++) begin
      int c;
      c = (mPtr + k) % N_CH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  localparam logic [31:0] D  = 32'h13121110;
  localparam logic [31:0] DB = 32'h13A51110;

  vec_t mainVec[22];
  vec_t lockVec[5];

  initial begin
    mainVec[0]  = '{4'hF, 4'hF, D,  1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 1'b1};
    mainVec[1]  = '{4'hF, 4'hF, D,  1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 1'b1};
    mainVec[2]  = '{4'hF, 4'hF, D,  1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12, 1'b1};
    mainVec[3]  = '{4'hF, 4'hF, D,  1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13, 1'b1};
    mainVec[4]  = '{4'hF, 4'hF, D,  1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 1'b1};
    mainVec[5]  = '{4'hF, 4'hF, DB, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 1'b1};
    mainVec[6]  = '{4'hF, 4'hF, DB, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5, 1'b1};
    mainVec[7]  = '{4'hF, 4'hF, DB, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5, 1'b1};
    mainVec[8]  = '{4'hF, 4'hF, DB, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5, 1'b1};
    mainVec[9]  = '{4'hF, 4'hF, DB, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5, 1'b1};
    mainVec[10] = '{4'hF, 4'hF, DB, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13, 1'b1};
    mainVec[11] = '{4'hF, 4'hF, D,  1'b1, 2'd1, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 1'b1};
    mainVec[12] = '{4'hF, 4'hF, D,  1'b1, 2'd1, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 1'b1};
    mainVec[13] = '{4'hD, 4'hF, D,  1'b1, 2'd1, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0};
    mainVec[14] = '{4'h8, 4'hF, D,  1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13, 1'b1};
    mainVec[15] = '{4'h1, 4'hF, D,  1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 1'b1};
    mainVec[16] = '{4'h8, 4'hF, D,  1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13, 1'b1};
    mainVec[17] = '{4'h1, 4'hF, D,  1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 1'b1};
    mainVec[18] = '{4'h0, 4'hF, D,  1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0};
    mainVec[19] = '{4'h0, 4'hF, D,  1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0};
    mainVec[20] = '{4'h4, 4'hF, D,  1'b0, 2'd0, 1'b0, 4'b0100, 1'b1, 2'd2, 8'h12, 1'b1};
    mainVec[21] = '{4'h4, 4'hF, D,  1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h12, 1'b1};

`ifdef RR_STREAM_MUX_LOCK_EN
    lockVec[0] = '{4'h6, 4'h0, D, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 1'b0};
    lockVec[1] = '{4'h6, 4'h0, D, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 1'b0};
    lockVec[2] = '{4'h4, 4'h0, D, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0};
    lockVec[3] = '{4'h6, 4'h2, D, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 1'b1};
    lockVec[4] = '{4'h6, 4'h6, D, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12, 1'b1};
`else
    lockVec[0] = '{4'h6, 4'h0, D, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 1'b0};
    lockVec[1] = '{4'h6, 4'h0, D, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12, 1'b0};
    lockVec[2] = '{4'h4, 4'h0, D, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12, 1'b0};
    lockVec[3] = '{4'h6, 4'h2, D, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 1'b1};
    lockVec[4] = '{4'h6, 4'h6, D, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12, 1'b1};
`endif

    d6Data     = 48'h252423222120;
    d6Valid    = 6'h00;
    d6Last     = 6'h3F;
    d6Mode     = 1'b0;
    d6ForceSel = 3'd0;
    d6OutReady = 1'b1;

    // Power-on reset
    applyStimulus(4'h0, 4'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    rst = 1'b1;
    #3;
    checkOutput("reset.out_valid", 32'(outValid), 32'h0);
    checkOutput("reset.out_data", 32'(outData), 32'h0);
    checkOutput("reset.out_last", 32'(outLast), 32'h0);
    checkOutput("reset.out_sel", 32'(outSel), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 22; i++) runVector(mainVec[i], "main", i);

    // Reset while a beat is held and all channels request
    applyStimulus(4'hF, 4'hF, D, 1'b0, 2'd0, 1'b0);
    rst = 1'b1;
    #2;
    checkOutput("midreset.out_valid", 32'(outValid), 32'h0);
    checkOutput("midreset.out_data", 32'(outData), 32'h0);
    checkOutput("midreset.out_sel", 32'(outSel), 32'h0);
    checkOutput("midreset.out_last", 32'(outLast), 32'h0);
    checkOutput("midreset.in_ready", 32'(inReady), 32'h0);
    applyStimulus(4'h0, 4'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] packet lock sequence");
    for (int i = 0; i < 5; i++) runVector(lockVec[i], "lock", i);

    $display("[TB] randomized run against model");
    resetDut();
    mPtr    = N_CH - 1;
    mValid  = 1'b0;
    mData   = 8'h00;
    mLast   = 1'b0;
    mSel    = 0;
    mLocked = 1'b0;
    mLockCh = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [3:0]  v;
      logic [3:0]  l;
      logic [31:0] d;
      logic        m;
      logic [1:0]  fs;
      logic        r;
      logic [3:0]  expReady;
      bit          loadEn;
      int          g;
      v  = 4'($urandom);
      l  = 4'($urandom);
      d  = $urandom;
      m  = ($urandom_range(0, 3) == 0);
      fs = 2'($urandom_range(0, 3));
      r  = ($urandom_range(0, 9) < 7);
      applyStimulus(v, l, d, m, fs, r);
      loadEn   = !mValid || r;
      g        = modelGrant(v, m, fs);
      expReady = (g >= 0 && loadEn) ? 4'(1 << g) : 4'h0;
      #2;
      checkOutput($sformatf("rand[%0d].in_ready", cyc), 32'(inReady), 32'(expReady));
      checkOutput($sformatf("rand[%0d].out_valid", cyc), 32'(outValid), 32'(mValid));
      if (mValid) begin
        checkOutput($sformatf("rand[%0d].out_sel", cyc), 32'(outSel), 32'(mSel));
        checkOutput($sformatf("rand[%0d].out_data", cyc), 32'(outData), 32'(mData));
        checkOutput($sformatf("rand[%0d].out_last", cyc), 32'(outLast), 32'(mLast));
      end
      if (loadEn) begin
        mValid = (g >= 0);
        if (g >= 0) begin
          mData = d[g*8 +: 8];
          mLast = l[g];
          mSel  = g;
        end
      end
      if (m) begin
        mLocked = 1'b0;
      end else if (loadEn && g >= 0) begin
`ifdef RR_STREAM_MUX_LOCK_EN
        if (l[g]) begin
          mLocked = 1'b0;
          mPtr    = g;
        end else begin
          mLocked = 1'b1;
          mLockCh = g;
        end
`else
        mPtr = g;
`endif
      end
      @(posedge clk);
      #1;
    end

    $display("[TB] six-channel forced select range");
    applyStimulus(4'h0, 4'h0, 32'h0, 1'b0, 2'd0, 1'b1);
    d6Valid    = 6'h3F;
    d6Mode     = 1'b1;
    d6ForceSel = 3'd5;
    #2;
    checkOutput("ch6.fsel5.in_ready", 32'(d6Ready), 32'h20);
    @(posedge clk);
    #1;
    checkOutput("ch6.fsel5.out_valid", 32'(d6OutValid), 32'h1);
    checkOutput("ch6.fsel5.out_sel", 32'(d6OutSel), 32'h5);
    checkOutput("ch6.fsel5.out_data", 32'(d6OutData), 32'h25);
    d6ForceSel = 3'd6;
    #2;
    checkOutput("ch6.fsel6.in_ready", 32'(d6Ready), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("ch6.fsel6.out_valid", 32'(d6OutValid), 32'h0);
    d6ForceSel = 3'd7;
    #2;
    checkOutput("ch6.fsel7.in_ready", 32'(d6Ready), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("ch6.fsel7.out_valid", 32'(d6OutValid), 32'h0);
    d6Mode = 1'b0;
    #2;
    checkOutput("ch6.rr0.in_ready", 32'(d6Ready), 32'h01);
    @(posedge clk);
    #1;
    checkOutput("ch6.rr0.out_sel", 32'(d6OutSel), 32'h0);
    #2;
    checkOutput("ch6.rr1.in_ready", 32'(d6Ready), 32'h02);
    @(posedge clk);
    #1;
    checkOutput("ch6.rr1.out_sel", 32'(d6OutSel), 32'h1);
    checkOutput("ch6.rr1.out_data", 32'(d6OutData), 32'h21);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
Parametrised, registered N-channel stream multiplexer; successor to the fixed 2/4/8:1 combinational muxes.
- Selects one of N_CH valid/ready input streams per beat, by round-robin arbitration or a forced select.
- Drives one registered output stream.
- Sits between producer channels and a shared downstream consumer; provides fair sharing and correct backpressure.

Parameters:
N_CH, 4, number of input channels (>=2)
DATA_W, 8, data width per channel
SEL_W, $clog2(N_CH), width of select/index fields (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_data  in  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
in_valid  in  N_CH  per-channel valid
in_last  in  N_CH  per-channel end-of-packet marker
in_ready  out  N_CH  per-channel ready
mode  in  1  0 = round-robin, 1 = forced select
force_sel  in  SEL_W  channel index used when mode=1
out_data  out  DATA_W  registered output data
out_valid  out  1  output valid
out_last  out  1  registered copy of accepted in_last
out_sel  out  SEL_W  index of channel that supplied current output beat
out_ready  in  1  downstream ready

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_last=0, out_sel=0, rr pointer ptr=N_CH-1 (channel 0 highest priority first), lock state cleared.
- Output register is one entry. load_en = !out_valid | out_ready. Register loads on the clk edge when load_en and a grant exist.
- Latency: an input beat accepted at edge t appears on out_* immediately after t. One cycle, no bubble under continuous out_ready=1.
- in_ready[i] = grant[i] & load_en. Combinational from in_valid, mode, force_sel, ptr and out_ready; at most one bit set. Transfer on channel i = in_valid[i] & in_ready[i].
- Round-robin grant (mode=0): first valid channel searching ptr+1, ptr+2, ... modulo N_CH. No valid inputs means no grant.
- ptr updates to the granted index only on an accepted transfer in mode 0. ptr is unchanged in mode 1.
- Forced grant (mode=1): grant = force_sel if force_sel < N_CH and in_valid[force_sel]. Otherwise no grant; force_sel >= N_CH never grants.
- Held output beat (out_valid=1, out_ready=0): out_data, out_last and out_sel are stable. All in_ready = 0.
- Simultaneous drain and refill (out_valid=1, out_ready=1, new grant): new beat replaces old in the same edge.
- Drain with no grant: out_valid drops to 0.
- Changes to mode or force_sel affect only the next arbitration, never a held beat.
- Reset mid-transfer discards the output register. No partial state survives.
- Producers must hold data stable while valid & !ready. The block does not check this.

Optional Feature:
RR_STREAM_MUX_LOCK_EN
- Enabled: in mode 0, after accepting a beat with in_last=0 from channel k, grant is locked to k until a beat with in_last=1 from k is accepted. Other channels get in_ready=0 even if k is idle. ptr advances only on the last beat.
- Mode 1 ignores and clears the lock.
- Disabled: arbitration is per beat; in_last is only passed through to out_last.

Decomposition:
- Package rr_stream_mux_pkg holds MODE_RR=1'b0, MODE_FORCE=1'b1, and the lock-state encoding.
- Natural sub-module: rr_arbiter. Parameter N_CH; inputs req[N_CH], ptr, advance. Outputs one-hot grant and grant index. Reusable across other shared-resource blocks.

Test Plan:
- Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_sel=0, all in_ready=0 while rst high.
- RR fairness: N_CH=4, all valid continuously, data=0x10+i, out_ready=1 -> out_sel sequence 0,1,2,3,0,... and out_data 0x10,0x11,0x12,0x13,0x10. One beat per cycle.
- Backpressure: out_ready=0 for 3 cycles with beat 0xA5 from ch2 held -> out_data=0xA5, out_sel=2 stable, in_ready=0000. Release -> next beat from ch3.
- Forced mode: mode=1, force_sel=1, all valid -> only ch1 beats. force_sel=5 (with N_CH=4 via SEL_W=2 truncation test at N_CH=6: force_sel=6) -> no grant, out_valid falls.
- Sparse valid: only ch3 then ch0 valid alternately -> grants follow valid with no idle bubbles and no spurious grants.
- Lock (macro on): ch1 sends 3-beat packet (last on beat 3) while ch2 valid -> out_sel=1,1,1 then 2. Macro off -> 1,2,1,2 interleave.
